jtag_data_reg: RTL and testbench

- Parametrised JTAG data register, successor to the 1-bit bypass stage.
- Provides capture/shift/update of a WIDTH-bit parallel word between TDI and TDO, with a run-time bypass mode and a shift-length checker.
- Sits behind the TAP controller; CAPTURE/SHIFT/UPDATE strobes come from TAP state decode, qualified by SELECT from the instruction decoder.

---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_shift_counter.sv | 28 ++
 rtl/jtag_data_reg.sv | 108 ++++++++++
 tb/tb_jtag_data_reg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG register definitions: DR FSM encoding, strobe priority and counter sizing.
package jtag_pkg;

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_CAPD = 2'd1,
    DR_SHFT = 2'd2
  } dr_state_e;

  typedef struct packed {
    logic cap;
    logic shf;
    logic upd;
  } dr_stb_t;

  localparam dr_stb_t STB_NONE = '0;

  // Highest-priority strobe wins: CAPTURE > SHIFT > UPDATE.
  function automatic dr_stb_t stb_pick(input dr_stb_t raw);
    dr_stb_t r;
    r     = STB_NONE;
    r.cap = raw.cap;
    r.shf = raw.shf & ~raw.cap;
    r.upd = raw.upd & ~raw.cap & ~raw.shf;
    return r;
  endfunction

  function automatic logic stb_conflict(input dr_stb_t raw);
    return (raw.cap & raw.shf) | (raw.cap & raw.upd) | (raw.shf & raw.upd);
  endfunction

  // Counter must hold the saturation value WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/jtag_shift_counter.sv
// Saturating shifted-bit counter with an exact-length compare; shared by DR and IR.
module jtag_shift_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full
);

  localparam logic [CNT_W-1:0] SAT  = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (i_clr)                r_cnt <= '0;
    else if (i_inc && r_cnt != SAT) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_full = (r_cnt == FULL);

endmodule

// File: rtl/jtag_data_reg.sv
// WIDTH-bit JTAG data register with run-time bypass and protocol checking.
// Define JTAG_DR_LENCHK_EN to gate UPDATE on exactly WIDTH shifted bits.
module jtag_data_reg
  import jtag_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = cnt_width(WIDTH)
) (
  input  logic             TCK,
  input  logic             TRST_N,
  input  logic             TDI,
  input  logic             SELECT,
  input  logic             BYPASS,
  input  logic             CAPTURE,
  input  logic             SHIFT,
  input  logic             UPDATE,
  input  logic [WIDTH-1:0] PIN,
  output logic [WIDTH-1:0] POUT,
  output logic             UPD_STB,
  output logic             TDO,
  output logic             PROTO_ERR
);

  dr_state_e        r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_pout;
  logic             r_byp;
  logic             r_mode_q;
  logic             r_upd_stb;
  logic             r_err;

  dr_stb_t          w_raw;
  dr_stb_t          w_stb;
  logic             w_multi;
  logic             w_mode_chg;
  logic             w_idle_op;
  logic             w_len_ok;
  logic             w_upd_ok;
  logic             w_load;
  logic             w_len_err;
  logic [CNT_W-1:0] w_cnt;

  assign w_raw      = SELECT ? dr_stb_t'{cap: CAPTURE, shf: SHIFT, upd: UPDATE} : STB_NONE;
  assign w_stb      = stb_pick(w_raw);
  assign w_multi    = stb_conflict(w_raw);
  assign w_mode_chg = (BYPASS != r_mode_q) && (r_state != DR_IDLE);
  assign w_idle_op  = (w_stb.shf | w_stb.upd) && (r_state == DR_IDLE);

  jtag_shift_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .i_clk   (TCK),
    .i_rst_n (TRST_N),
    .i_clr   (w_stb.cap & ~BYPASS),
    .i_inc   (w_stb.shf & ~BYPASS),
    .o_cnt   (w_cnt),
    .o_full  (w_len_ok)
  );

`ifdef JTAG_DR_LENCHK_EN
  assign w_upd_ok = w_len_ok;
`else
  // Length result is informational only in this build; UPDATE always loads.
  assign w_upd_ok = w_len_ok | 1'b1;
`endif

  assign w_load    = w_stb.upd & ~BYPASS & w_upd_ok;
  assign w_len_err = w_stb.upd & ~BYPASS & ~w_upd_ok;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_state   <= DR_IDLE;
      r_upd_stb <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_upd_stb <= w_load;
      if (w_multi || w_mode_chg || w_idle_op || w_len_err) r_err <= 1'b1;
      if (w_stb.cap)                              r_state <= DR_CAPD;
      else if (w_stb.shf && r_state != DR_IDLE)   r_state <= DR_SHFT;
      else if (w_stb.upd)                         r_state <= DR_IDLE;
    end
  end

  // Mode tracker follows BYPASS every cycle so a flip is seen exactly once.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_sr     <= RESET_VALUE;
      r_pout   <= RESET_VALUE;
      r_byp    <= 1'b0;
      r_mode_q <= 1'b0;
    end else begin
      r_mode_q <= BYPASS;
      if (w_stb.cap) begin
        if (BYPASS) r_byp <= 1'b0;
        else        r_sr  <= PIN;
      end else if (w_stb.shf) begin
        if (BYPASS) r_byp <= TDI;
        else        r_sr  <= {TDI, r_sr[WIDTH-1:1]};
      end
      if (w_load) r_pout <= r_sr;
    end
  end

  assign TDO       = BYPASS ? r_byp : r_sr[0];
  assign POUT      = r_pout;
  assign UPD_STB   = r_upd_stb;
  assign PROTO_ERR = r_err;

endmodule

// File: tb/tb_jtag_data_reg.sv
// Scoreboard bench for jtag_data_reg (WIDTH=8); covers both JTAG_DR_LENCHK_EN builds.
module tb_jtag_data_reg;

  localparam int W = 8;
  localparam int S_POUT = 0, S_TDO = 1, S_STB = 2, S_ERR = 3;

  logic         TCK = 1'b0;
  logic         TRST_N, TDI, SELECT, BYPASS, CAPTURE, SHIFT, UPDATE;
  logic [W-1:0] PIN, POUT;
  logic         UPD_STB, TDO, PROTO_ERR;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  jtag_data_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TDI(TDI), .SELECT(SELECT), .BYPASS(BYPASS),
    .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE), .PIN(PIN),
    .POUT(POUT), .UPD_STB(UPD_STB), .TDO(TDO), .PROTO_ERR(PROTO_ERR)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] obs(input int s);
    case (s)
      S_POUT:  return POUT;
      S_TDO:   return {7'd0, TDO};
      S_STB:   return {7'd0, UPD_STB};
      default: return {7'd0, PROTO_ERR};
    endcase
  endfunction

  task automatic push(input string tag, input int s, input logic [7:0] e);
    sb_t it;
    it.tag = tag; it.sig = s; it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic drain();
    sb_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      chk(it.tag, obs(it.sig), it.exp);
    end
  endtask

  task automatic step();
    @(posedge TCK); #1;
    drain();
  endtask

  task automatic clr_stb();
    CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0;
  endtask

  task automatic do_reset();
    TRST_N = 1'b0; clr_stb(); BYPASS = 1'b0; SELECT = 1'b1; TDI = 1'b0;
    @(posedge TCK); #1;
    TRST_N = 1'b1;
  endtask

  task automatic shift_n(input int n, input logic tdi);
    for (int i = 0; i < n; i++) begin
      SHIFT = 1'b1; TDI = tdi; step();
    end
    SHIFT = 1'b0;
  endtask

  initial begin
    logic [7:0] a5, c3;
    logic [7:0] tdi_seq;
    logic [2:0] byp_tdi, byp_exp;
    a5 = 8'hA5; c3 = 8'h3C; tdi_seq = 8'b1100_1101; byp_tdi = 3'b011; byp_exp = 3'b110;

    TRST_N = 1'b0; TDI = 1'b0; SELECT = 1'b1; BYPASS = 1'b0; PIN = '0; clr_stb();
    #2;
    push("rst_pout", S_POUT, 8'h00); push("rst_tdo", S_TDO, 8'h0);
    push("rst_stb", S_STB, 8'h0);    push("rst_err", S_ERR, 8'h0);
    drain();
    @(posedge TCK); #1; TRST_N = 1'b1;

    // capture A5, shift 8 bits, update
    PIN = a5; CAPTURE = 1'b1; step(); CAPTURE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push("t1_tdo", S_TDO, {7'd0, a5[i]}); drain();
      SHIFT = 1'b1; TDI = tdi_seq[i]; step();
    end
    SHIFT = 1'b0;
    UPDATE = 1'b1;
    push("t1_pout", S_POUT, 8'hCD); push("t1_stb", S_STB, 8'h1);
    step(); UPDATE = 1'b0;
    push("t1_stb_low", S_STB, 8'h0); push("t1_err", S_ERR, 8'h0);
    step();

    // bypass path, mode flip while idle is legal
    BYPASS = 1'b1; CAPTURE = 1'b1; step(); CAPTURE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("t2_tdo", S_TDO, {7'd0, byp_exp[i]}); drain();
      SHIFT = 1'b1; TDI = byp_tdi[i]; step();
    end
    SHIFT = 1'b0; UPDATE = 1'b1;
    push("t2_pout", S_POUT, 8'hCD); push("t2_stb", S_STB, 8'h0); push("t2_err", S_ERR, 8'h0);
    step(); UPDATE = 1'b0; BYPASS = 1'b0;

    // capture+shift together: capture wins, error set
    PIN = c3; CAPTURE = 1'b1; SHIFT = 1'b1;
    push("t4_err", S_ERR, 8'h1);
    step(); clr_stb();
    for (int i = 0; i < 8; i++) begin
      push("t4_tdo", S_TDO, {7'd0, c3[i]}); drain();
      SHIFT = 1'b1; TDI = 1'b0; step();
    end
    SHIFT = 1'b0;

    // async reset mid-shift
    PIN = 8'hFF; CAPTURE = 1'b1; step(); CAPTURE = 1'b0;
    shift_n(4, 1'b1);
    push("t5_pre_tdo", S_TDO, 8'h1); push("t5_pre_pout", S_POUT, 8'hCD); drain();
    TRST_N = 1'b0; #1;
    push("t5_pout", S_POUT, 8'h00); push("t5_tdo", S_TDO, 8'h0);
    push("t5_err", S_ERR, 8'h0);    push("t5_stb", S_STB, 8'h0);
    drain();
    @(posedge TCK); #1; TRST_N = 1'b1;
    SHIFT = 1'b1; TDI = 1'b0;
    push("t5_idle", S_ERR, 8'h1);
    step(); SHIFT = 1'b0;

    // bypass flip while not idle
    do_reset();
    CAPTURE = 1'b1; step(); CAPTURE = 1'b0;
    push("mode_ok", S_ERR, 8'h0); drain();
    BYPASS = 1'b1;
    push("mode_chg", S_ERR, 8'h1);
    step(); BYPASS = 1'b0; step();

    // length check: 7 shifts, then 8 shifts
    do_reset();
    PIN = 8'h00; CAPTURE = 1'b1; step(); CAPTURE = 1'b0;
    shift_n(7, 1'b1);
    UPDATE = 1'b1;
`ifdef JTAG_DR_LENCHK_EN
    push("t3_short_pout", S_POUT, 8'h00); push("t3_short_stb", S_STB, 8'h0);
    push("t3_short_err", S_ERR, 8'h1);
`else
    push("t3_short_pout", S_POUT, 8'hFE); push("t3_short_stb", S_STB, 8'h1);
    push("t3_short_err", S_ERR, 8'h0);
`endif
    step(); UPDATE = 1'b0;
    do_reset();
    CAPTURE = 1'b1; step(); CAPTURE = 1'b0;
    shift_n(8, 1'b1);
    UPDATE = 1'b1;
    push("t3_full_pout", S_POUT, 8'hFF); push("t3_full_stb", S_STB, 8'h1);
    push("t3_full_err", S_ERR, 8'h0);
    step(); UPDATE = 1'b0; step();

    // deselected: strobes ignored, outputs and FSM hold
    BYPASS = 1'b1; CAPTURE = 1'b1; step(); CAPTURE = 1'b0;
    SHIFT = 1'b1; TDI = 1'b1; step(); SHIFT = 1'b0;
    push("t6_pre_tdo", S_TDO, 8'h1); drain();
    SELECT = 1'b0;
    for (int i = 0; i < 10; i++) begin
      CAPTURE = 1'($urandom_range(0, 1)); SHIFT = 1'($urandom_range(0, 1));
      UPDATE = 1'($urandom_range(0, 1));  TDI = 1'($urandom_range(0, 1));
      push("t6_tdo", S_TDO, 8'h1); push("t6_pout", S_POUT, 8'hFF);
      push("t6_stb", S_STB, 8'h0);
      step();
    end
    clr_stb(); SELECT = 1'b1; UPDATE = 1'b1;
    push("t6_fsm", S_ERR, 8'h0);
    step(); UPDATE = 1'b0;
    push("t6_post_pout", S_POUT, 8'hFF);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
